operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Input stage that sits directly upstream of the multiplier/peripheral datapath.
- Assembles two 32-bit operands, dataA then dataB, from eight byte-wide switch entries, one byte per debounced press of the enter pushbutton.
- Presents both operands to the multiplier unit and raises inputdata_ready once both are complete.
- A load sequence is started by the control unit through loaddata.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive cycles enter must hold a new level before the level is accepted (minimum 1).
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- enter  input  1  raw pushbutton, active-high, may bounce.
- inputdata  input  8  switch byte captured on each accepted press.
- loaddata  input  1  start/restart request from the control unit; single-cycle pulse or level.
- inputdata_ready  output  1  high while dataA and dataB both hold complete operands.
- dataA  output  32  operand A to the multiplier.
- dataB  output  32  operand B to the multiplier.
- load_stage  output  4  progress indicator for the displays: 0 = idle, 1..4 = next byte of A, 5..8 = next byte of B, 9 = ready.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - dataA = 0, dataB = 0.
  - inputdata_ready = 0, load_stage = 0.
  - State = IDLE, debounce counter = 0, debounced level = 0, press pulse = 0.
- Debouncer:
  - The counter increments while the sampled enter differs from the debounced level. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while enter still differs, the debounced level flips on that edge and the counter clears.
  - A 0->1 flip of the debounced level generates a registered one-cycle press pulse on the following cycle.
  - Net latency: with enter stable high from before edge k, the byte is captured at edge k+DEBOUNCE_CYCLES.
  - One press produces exactly one pulse regardless of hold time.
  - Release must be stable low for DEBOUNCE_CYCLES before another press can be accepted.
- FSM states:
  - IDLE: press pulses ignored. loaddata=1 -> LOAD_A; byte index = 0, dataA = 0, dataB = 0, inputdata_ready = 0.
  - LOAD_A: each press pulse writes inputdata into dataA, MSB byte first:
    - index 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
    - The index increments; after index 3 the index wraps to 0 and the state becomes LOAD_B.
  - LOAD_B: identical to LOAD_A, writing dataB. After index 3 -> READY, and inputdata_ready = 1 on that same edge.
  - READY: operands held stable, press pulses ignored, inputdata_ready = 1. loaddata=1 -> LOAD_A with both operands cleared and inputdata_ready = 0 on that edge.
- load_stage is a registered value: 0 in IDLE, index+1 in LOAD_A, index+5 in LOAD_B, 9 in READY.
- Simultaneous events:
  - loaddata=1 and a press pulse in the same cycle in LOAD_A or LOAD_B: loaddata wins. The sequence restarts, both operands clear, and the press is discarded.
  - loaddata held high: the FSM stays in LOAD_A at index 0 and discards presses until loaddata drops.
- Reset mid-sequence: all registers return to their reset values on the next edge, including the debouncer. A press that is held through reset counts only after a stable release and a new press.
- Operand outputs change only on capture or clear edges; they never glitch between those edges.

Optional Feature:
- Macro LOADER_INPUT_SYNC_EN.
- When defined: enter passes through a 2-flop synchronizer and inputdata through a 2-stage register before use. Capture latency increases by exactly 2 cycles, and the captured byte is the switch value from 2 cycles earlier.
- When undefined: enter and inputdata are used directly, with the latency stated in Behaviour.

Test Plan:
- Reset and idle: assert reset 2 cycles, then press enter with inputdata=8'hFF while in IDLE. Required: dataA = dataB = 0, inputdata_ready = 0, load_stage = 0.
- Full load: pulse loaddata, then press 8 clean presses with bytes 3F,C0,00,00,40,00,00,00. Required: dataA = 32'h3FC00000, dataB = 32'h40000000, inputdata_ready rises on the edge of the 8th capture, load_stage = 9.
- Bounce rejection (DEBOUNCE_CYCLES=4): during LOAD_A, toggle enter 1,0,1,0 for single cycles, then hold high for 6 cycles. Required: exactly one byte captured, captured at the edge predicted by the debouncer latency; load_stage goes 1 -> 2.
- Restart collision: after 5 captures, assert loaddata in the same cycle as a press pulse. Required: dataA = dataB = 0, load_stage = 1, press discarded, inputdata_ready = 0.
- Reset mid-load: after 3 captures, assert reset for 1 cycle while enter is held high. Required: all outputs 0, and no capture until enter is released stably and pressed again.
- Hold and reload: in READY, make 3 presses with varying bytes. Required: operands unchanged, inputdata_ready = 1. Then pulse loaddata. Required: inputdata_ready = 0 and operands cleared on that edge.

Source files
------------

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
//
// Input stage in front of the multiplier datapath. Builds two 32-bit operands,
// dataA then dataB, from eight switch bytes, one byte per debounced press of
// the enter pushbutton, most significant byte first. A load sequence is
// started (or restarted) by loaddata from the control unit.
//
// Optional build macro:
//   LOADER_INPUT_SYNC_EN - when defined, enter goes through a 2-flop
//                          synchronizer and inputdata through a 2-stage
//                          register before use (capture latency +2 cycles).
//
// Parameters:
//   DEBOUNCE_CYCLES - cycles enter must hold a new level before it is accepted
//                     (minimum 1)
//   CNT_W           - debounce counter width, 2^CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk             - system clock, rising edge active
//   reset           - synchronous, active-high reset
//   enter           - raw pushbutton, active high, may bounce
//   inputdata[7:0]  - switch byte captured on each accepted press
//   loaddata        - start/restart request (pulse or level)
//   inputdata_ready - high while dataA and dataB both hold complete operands
//   dataA[31:0]     - operand A
//   dataB[31:0]     - operand B
//   load_stage[3:0] - 0 idle, 1..4 next byte of A, 5..8 next byte of B, 9 ready
// -----------------------------------------------------------------------------
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic [7:0]  inputdata,
  input  logic        loaddata,
  output logic        inputdata_ready,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [3:0]  load_stage
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    READY  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic       enter_use;
  logic [7:0] data_use;

`ifdef LOADER_INPUT_SYNC_EN
  logic       enter_meta;
  logic       enter_sync;
  logic [7:0] data_d1;
  logic [7:0] data_d2;

  // The switch byte is delayed by the same two stages as enter so that the
  // byte captured belongs to the same moment as the press that captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_meta <= 1'b0;
      enter_sync <= 1'b0;
      data_d1    <= 8'h00;
      data_d2    <= 8'h00;
    end else begin
      enter_meta <= enter;
      enter_sync <= enter_meta;
      data_d1    <= inputdata;
      data_d2    <= data_d1;
    end
  end

  assign enter_use = enter_sync;
  assign data_use  = data_d2;
`else
  assign enter_use = enter;
  assign data_use  = inputdata;
`endif

  // ---------------------------------------------------------------------------
  // Debouncer: a new level is accepted after DEBOUNCE_CYCLES consecutive
  // samples that differ from the current debounced level. Any matching sample
  // restarts the count, so bounces shorter than that are rejected.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] db_cnt;
  logic             db_level;
  logic             press;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (enter_use != db_level) begin
        if (db_cnt == CNT_LAST) begin
          db_level <= enter_use;
          db_cnt   <= '0;
          // Only the rising flip of the level is a press; it is visible for
          // exactly the one cycle after the flip edge.
          press    <= enter_use;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [31:0] data_a_n, data_b_n;
  logic        ready_n;
  logic [3:0]  stage_n;

  // Write one byte into a word, index 0 addressing the most significant byte.
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  value);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[31:24] = value;
      2'd1:    w[23:16] = value;
      2'd2:    w[15:8]  = value;
      default: w[7:0]   = value;
    endcase
    return w;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    data_a_n   = dataA;
    data_b_n   = dataB;
    ready_n    = inputdata_ready;

    // loaddata restarts from any state and beats a simultaneous press.
    if (loaddata) begin
      state_n    = LOAD_A;
      byte_idx_n = 2'd0;
      data_a_n   = 32'h0;
      data_b_n   = 32'h0;
      ready_n    = 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (press) begin
            data_a_n   = put_byte(dataA, byte_idx, data_use);
            byte_idx_n = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state_n = LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (press) begin
            data_b_n   = put_byte(dataB, byte_idx, data_use);
            byte_idx_n = byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state_n = READY;
              ready_n = 1'b1;
            end
          end
        end
        default: begin
          // IDLE and READY ignore presses and only leave on loaddata.
        end
      endcase
    end

    // Progress indicator derived from where the FSM will be after this edge.
    case (state_n)
      LOAD_A:  stage_n = 4'd1 + {2'b00, byte_idx_n};
      LOAD_B:  stage_n = 4'd5 + {2'b00, byte_idx_n};
      READY:   stage_n = 4'd9;
      default: stage_n = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      byte_idx        <= 2'd0;
      dataA           <= 32'h0;
      dataB           <= 32'h0;
      inputdata_ready <= 1'b0;
      load_stage      <= 4'd0;
    end else begin
      state           <= state_n;
      byte_idx        <= byte_idx_n;
      dataA           <= data_a_n;
      dataB           <= data_b_n;
      inputdata_ready <= ready_n;
      load_stage      <= stage_n;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_loader
//
// Directed bench for operand_loader. A behavioural model tracks the expected
// outputs (debounce as a run length of differing samples, the load sequence as
// a single stage number 0..9) and is compared against the DUT on every falling
// edge. Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_operand_loader;

  localparam int D = 4;
`ifdef LOADER_INPUT_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic        clk;
  logic        reset;
  logic        enter;
  logic [7:0]  inputdata;
  logic        loaddata;
  logic        inputdata_ready;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [3:0]  load_stage;

  int n_checks = 0;
  int n_errors = 0;

  operand_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .enter           (enter),
    .inputdata       (inputdata),
    .loaddata        (loaddata),
    .inputdata_ready (inputdata_ready),
    .dataA           (dataA),
    .dataB           (dataB),
    .load_stage      (load_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          m_run;
  bit          m_lvl;
  bit          m_press;
  int          m_stage;
  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          m_started = 1'b0;
  bit          m_e1, m_e2;
  logic [7:0]  m_d1, m_d2;

  always @(posedge clk) begin
    bit         e_s;
    logic [7:0] d_s;
`ifdef LOADER_INPUT_SYNC_EN
    e_s  = m_e2;
    d_s  = m_d2;
    m_e2 = m_e1;
    m_e1 = enter;
    m_d2 = m_d1;
    m_d1 = inputdata;
`else
    e_s = enter;
    d_s = inputdata;
`endif
    if (reset) begin
      m_run = 0; m_lvl = 0; m_press = 0;
      m_stage = 0; m_a = 0; m_b = 0;
      m_e1 = 0; m_e2 = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      // Sequence: loaddata restarts everything, otherwise a press fills the
      // next byte while a byte is still outstanding.
      if (loaddata) begin
        m_stage = 1; m_a = 0; m_b = 0;
      end else if (m_press && m_stage >= 1 && m_stage <= 8) begin
        if (m_stage <= 4) m_a[31 - 8*(m_stage-1) -: 8] = d_s;
        else              m_b[31 - 8*(m_stage-5) -: 8] = d_s;
        m_stage++;
      end
      // Debounce: D differing samples in a row accept the new level.
      m_press = 0;
      if (e_s != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl   = e_s;
          m_run   = 0;
          m_press = e_s;
        end
      end else begin
        m_run = 0;
      end
    end
    m_started = 1'b1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_ready", {31'b0, inputdata_ready}, {31'b0, m_stage == 9});
      check("model_dataA", dataA, m_a);
      check("model_dataB", dataB, m_b);
      check("model_stage", {28'b0, load_stage}, 32'(m_stage));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic press(input logic [7:0] b);
    inputdata = b;
    enter     = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    enter = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic pulse_load();
    loaddata = 1'b1;
    @(negedge clk);
    loaddata = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic rdy, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] st);
    check({tag, "_ready"}, {31'b0, inputdata_ready}, {31'b0, rdy});
    check({tag, "_dataA"}, dataA, a);
    check({tag, "_dataB"}, dataB, b);
    check({tag, "_stage"}, {28'b0, load_stage}, {28'b0, st});
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; inputdata = 8'h00; loaddata = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_outputs("reset", 1'b0, 32'h0, 32'h0, 4'd0);

    // Presses in IDLE are ignored.
    press(8'hFF);
    check_outputs("idle", 1'b0, 32'h0, 32'h0, 4'd0);

    // Full load of eight bytes; watch the eighth capture edge closely.
    pulse_load();
    check_outputs("start", 1'b0, 32'h0, 32'h0, 4'd1);
    press(8'h3F); press(8'hC0); press(8'h00); press(8'h00);
    check_outputs("a_done", 1'b0, 32'h3FC00000, 32'h0, 4'd5);
    press(8'h40); press(8'h00); press(8'h00);
    inputdata = 8'h00;
    enter     = 1'b1;
    repeat (LAT) @(negedge clk);
    check_outputs("pre_last", 1'b0, 32'h3FC00000, 32'h40000000, 4'd8);
    @(negedge clk);
    check_outputs("full", 1'b1, 32'h3FC00000, 32'h40000000, 4'd9);
    @(negedge clk);
    enter = 1'b0;
    repeat (LAT + 2) @(negedge clk);

    // READY holds the operands against further presses.
    press(8'h11); press(8'h22); press(8'h33);
    check_outputs("hold", 1'b1, 32'h3FC00000, 32'h40000000, 4'd9);

    // Reload clears on the loaddata edge.
    pulse_load();
    check_outputs("reload", 1'b0, 32'h0, 32'h0, 4'd1);

    // Bounce rejection: single-cycle toggles then a clean 6-cycle hold.
    inputdata = 8'hA5;
    enter = 1'b1; @(negedge clk);
    enter = 1'b0; @(negedge clk);
    enter = 1'b1; @(negedge clk);
    enter = 1'b0; @(negedge clk);
    enter = 1'b1;
    repeat (LAT) @(negedge clk);
    check_outputs("bounce_pre", 1'b0, 32'h0, 32'h0, 4'd1);
    @(negedge clk);
    check_outputs("bounce_cap", 1'b0, 32'hA5000000, 32'h0, 4'd2);
    @(negedge clk);
    enter = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_outputs("bounce_once", 1'b0, 32'hA5000000, 32'h0, 4'd2);

    // Restart collision: loaddata in the same cycle as the press pulse.
    press(8'h01); press(8'h02); press(8'h03); press(8'h04);
    check_outputs("five", 1'b0, 32'hA5010203, 32'h04000000, 4'd6);
    inputdata = 8'h77;
    enter     = 1'b1;
    repeat (LAT) @(negedge clk);
    loaddata = 1'b1;
    @(negedge clk);
    loaddata = 1'b0;
    check_outputs("collide", 1'b0, 32'h0, 32'h0, 4'd1);
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_outputs("collide_drop", 1'b0, 32'h0, 32'h0, 4'd1);

    // Reset mid-load with enter held through reset.
    press(8'h12); press(8'h34); press(8'h56);
    check_outputs("three", 1'b0, 32'h12345600, 32'h0, 4'd4);
    inputdata = 8'h9A;
    enter     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs("mid_reset", 1'b0, 32'h0, 32'h0, 4'd0);
    repeat (LAT + 4) @(negedge clk);
    pulse_load();
    repeat (LAT + 4) @(negedge clk);
    check_outputs("held_no_cap", 1'b0, 32'h0, 32'h0, 4'd1);
    enter = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    press(8'hBC);
    check_outputs("new_press", 1'b0, 32'hBC000000, 32'h0, 4'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
